// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: round-robin merge of N_INPUTS valid/ready streams into one registered output; `RR_STREAM_ARBITER_PKT_LOCK_EN keeps packets contiguous
module rr_stream_arbiter #(
  parameter int N_INPUTS = 4,
  parameter int WIDTH = 2,
  parameter int SEL_W = $clog2(N_INPUTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_INPUTS-1:0]       in_valid,
  output logic [N_INPUTS-1:0]       in_ready,
  input  logic [N_INPUTS*WIDTH-1:0] in_data,
  input  logic [N_INPUTS-1:0]       in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [SEL_W-1:0]          out_sel
);
  logic [SEL_W-1:0] ptr_q, cand, sel, nxt;
  logic any_v, locked, slot_free, xfer;
  // candidate is the first valid stream at or after ptr, wrapping around
  always_comb begin
    cand = ptr_q;
    any_v = 1'b0;
    for (int k = N_INPUTS - 1; k >= 0; k--) begin
      if (in_valid[(int'(ptr_q) + k) % N_INPUTS]) begin
        cand = SEL_W'((int'(ptr_q) + k) % N_INPUTS);
        any_v = 1'b1;
      end
    end
  end
`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state_q;
  logic [SEL_W-1:0] grant_q;
  assign locked = state_q == LOCKED;
  assign sel = locked ? grant_q : cand;
  // packet lock: hold the grant from the first beat until the beat carrying in_last
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else if (xfer) begin
      state_q <= in_last[sel] ? IDLE : LOCKED;
      grant_q <= in_last[sel] ? grant_q : sel;
    end
  end
`else
  assign locked = 1'b0;
  assign sel = cand;
`endif
  assign slot_free = !out_valid || out_ready;
  assign in_ready = (!rst && slot_free && (locked || any_v)) ? N_INPUTS'(1) << sel : '0;
  assign xfer = |(in_valid & in_ready);
  assign nxt = (sel == SEL_W'(N_INPUTS - 1)) ? '0 : sel + 1'b1;
  // one-stage output buffer and round-robin pointer advance
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_sel <= '0;
      ptr_q <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data <= in_data[sel*WIDTH +: WIDTH];
        out_last <= in_last[sel];
        out_sel <= sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
      if (xfer && in_last[sel]) ptr_q <= nxt;
`else
      if (xfer) ptr_q <= nxt;
`endif
    end
  end
endmodule

// File: tb/tb_rr_stream_arbiter.sv
// tb_rr_stream_arbiter: scoreboard bench for rr_stream_arbiter (N_INPUTS=4, WIDTH=2)
module tb_rr_stream_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] in_valid = '0;
  logic [3:0] in_ready;
  logic [7:0] in_data = '0;
  logic [3:0] in_last = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [1:0] out_data;
  logic out_last;
  logic [1:0] out_sel;
  int n_vec = 0;
  int n_err = 0;
  int m_ptr = 0;
  int m_grant = 0;
  bit m_lock = 0;
  bit m_ov = 0;
  logic [4:0] sb[$];
  int obs_sel[$];
  int exp_sel[$];
  logic [3:0] rdy_s;
  int b;

  rr_stream_arbiter #(.N_INPUTS(4), .WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_sel(string tag);
    check({tag, "_count"}, obs_sel.size(), exp_sel.size());
    for (int i = 0; i < exp_sel.size() && i < obs_sel.size(); i++) check(tag, obs_sel[i], exp_sel[i]);
  endtask

  // one clock: check handshake at negedge, score output beats, advance the reference at posedge
  task automatic cyc();
    logic [3:0] er;
    logic [4:0] beat, e;
    bit f, sf, x;
    int c, s;
    @(negedge clk);
    sf = !m_ov || out_ready;
    f = 0;
    c = 0;
    for (int k = 0; k < 4; k++) if (!f && in_valid[(m_ptr + k) % 4]) begin f = 1; c = (m_ptr + k) % 4; end
    s = m_lock ? m_grant : c;
    er = (rst || !sf || !(m_lock || f)) ? 4'b0 : 4'b1 << s;
    check("in_ready", in_ready, er);
    if (!rst) check("out_valid", out_valid, m_ov);
    rdy_s = in_ready;
    if (!rst && out_valid && out_ready) begin
      obs_sel.push_back(out_sel);
      if (sb.size() == 0) check("sb_size", sb.size(), 1);
      else begin
        e = sb.pop_front();
        check("out_beat", {out_sel, out_last, out_data}, e);
      end
    end
    x = !rst && |(in_valid & er);
    beat = {2'(s), in_last[s], in_data[s*2 +: 2]};
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_lock = 0; m_grant = 0; m_ov = 0;
      sb.delete();
    end else begin
      if (x) begin sb.push_back(beat); m_ov = 1; end
      else if (out_ready) m_ov = 0;
      if (x) begin
`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
        if (beat[2]) begin m_lock = 0; m_ptr = (s + 1) % 4; end
        else begin m_lock = 1; m_grant = s; end
`else
        m_ptr = (s + 1) % 4;
`endif
      end
    end
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    cyc();
    rst = 1'b0;
    repeat (5) begin
      cyc();
      check("idle_ov", out_valid, 0);
      check("idle_data", out_data, 0);
      check("idle_sel", out_sel, 0);
    end
    obs_sel.delete();
    in_valid = 4'hF;
    in_last = 4'hF;
    in_data = 8'b11_10_01_00;
    cyc();
    check("lat1", out_valid, 1);
    repeat (7) cyc();
    in_valid = 4'h0;
    repeat (2) cyc();
    exp_sel = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_sel("rr_seq");
    obs_sel.delete();
    in_valid = 4'b0110;
    in_last = 4'b0100;
    in_data = 8'h00;
    b = 0;
    for (int i = 0; i < 20 && b < 3; i++) begin
      in_data[3:2] = 2'(b + 1);
      in_last[1] = (b == 2);
      cyc();
`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
      check("lock_rdy2", rdy_s[2], 0);
`endif
      if (rdy_s[1]) b++;
    end
    check("pkt_beats", b, 3);
    in_valid = 4'b0100;
    cyc();
    in_valid = 4'h0;
    repeat (2) cyc();
`ifdef RR_STREAM_ARBITER_PKT_LOCK_EN
    exp_sel = '{1, 1, 1, 2};
`else
    exp_sel = '{1, 2, 1, 2, 1, 2};
`endif
    check_sel("pkt_seq");
    obs_sel.delete();
    out_ready = 1'b0;
    in_valid = 4'b0001;
    in_last = 4'b0001;
    in_data = 8'b10;
    cyc();
    in_data[1:0] = 2'b01;
    repeat (4) begin
      cyc();
      check("bp_ov", out_valid, 1);
      check("bp_data", out_data, 2'b10);
      check("bp_rdy", rdy_s, 0);
    end
    out_ready = 1'b1;
    cyc();
    in_valid = 4'h0;
    check("nb_ov", out_valid, 1);
    check("nb_data", out_data, 2'b01);
    repeat (2) cyc();
    obs_sel.delete();
    in_valid = 4'b1000;
    in_last = 4'hF;
    in_data = 8'b11_00_00_01;
    repeat (2) cyc();
    in_valid = 4'b1001;
    repeat (2) cyc();
    in_valid = 4'h0;
    repeat (2) cyc();
    exp_sel = '{3, 3, 0, 3};
    check_sel("wrap_seq");
    in_valid = 4'b0100;
    in_last = 4'h0;
    in_data = 8'b00_10_00_00;
    repeat (2) cyc();
    rst = 1'b1;
    in_valid = 4'h0;
    cyc();
    check("rst_ov", out_valid, 0);
    check("rst_rdy", in_ready, 0);
    rst = 1'b0;
    obs_sel.delete();
    in_valid = 4'b0101;
    in_last = 4'hF;
    in_data = 8'b00_11_00_01;
    repeat (2) cyc();
    in_valid = 4'h0;
    repeat (2) cyc();
    exp_sel = '{0, 2};
    check_sel("rst_seq");
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
